// File: rtl/click_decoder.sv
// Groups debounced press pulses into click gestures and presents each
// gesture's click count on a registered valid/ready output.
module click_decoder #(
    parameter int CLOCKS_PER_USEC   = 100,
    parameter int CLICK_WINDOW_MSEC = 300,
    parameter int MAX_CLICKS        = 3,
    parameter int SIM_WINDOW_CYCLES = 0,
    localparam int CW = $clog2(MAX_CLICKS + 1)
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          EDGE_IN,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [CW-1:0] OUT_COUNT,
    output logic          OVERFLOW,
    input  logic          OVF_CLEAR
);

    // state      | meaning
    // S_IDLE     | no gesture in progress, waiting for the first click
    // S_COUNTING | gesture open, window timer counting down to close it

    localparam int WINDOW_CYCLES = (SIM_WINDOW_CYCLES != 0) ? SIM_WINDOW_CYCLES
                                 : CLOCKS_PER_USEC * CLICK_WINDOW_MSEC * 1000;
    localparam int TW = $clog2(WINDOW_CYCLES + 1);

    localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(1);
    localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_CLICKS);
    localparam logic [CW-1:0] ONE_CLICK   = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_COUNTING
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] click_cnt, click_cnt_nx;
    logic [CW-1:0] click_inc;
    logic [TW-1:0] timer, timer_nx;
    logic          emit;
    logic [CW-1:0] emit_count;
    logic          emit_accept;
    logic          ovf_set;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_IDLE;
            click_cnt <= '0;
            timer     <= '0;
        end else begin
            state     <= state_nx;
            click_cnt <= click_cnt_nx;
            timer     <= timer_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        click_cnt_nx = click_cnt;
        timer_nx     = timer;
        emit         = 1'b0;
        emit_count   = '0;
        click_inc    = click_cnt + ONE_CLICK;

        case (state)
            S_IDLE: begin
                if (EDGE_IN) begin
                    click_cnt_nx = ONE_CLICK;
                    timer_nx     = WINDOW_LOAD;
                    state_nx     = S_COUNTING;
                end
            end
            S_COUNTING: begin
                // An edge on the last window cycle still belongs to this gesture.
                if (EDGE_IN) begin
                    if (click_inc == MAX_CNT) begin
                        emit         = 1'b1;
                        emit_count   = MAX_CNT;
                        click_cnt_nx = '0;
                        timer_nx     = '0;
                        state_nx     = S_IDLE;
                    end else begin
                        click_cnt_nx = click_inc;
                        timer_nx     = WINDOW_LOAD;
                    end
                end else if (timer == TIMER_LAST) begin
                    emit         = 1'b1;
                    emit_count   = click_cnt;
                    click_cnt_nx = '0;
                    timer_nx     = '0;
                    state_nx     = S_IDLE;
                end else begin
                    timer_nx = timer - TIMER_LAST;
                end
            end
            default: begin
                state_nx     = S_IDLE;
                click_cnt_nx = '0;
                timer_nx     = '0;
            end
        endcase
    end

    // A result that cannot be handed over is dropped; the held one stays put.
    assign emit_accept = emit && (!OUT_VALID || OUT_READY);
    assign ovf_set     = emit && OUT_VALID && !OUT_READY;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            OUT_VALID <= 1'b0;
            OUT_COUNT <= '0;
        end else if (emit_accept) begin
            OUT_VALID <= 1'b1;
            OUT_COUNT <= emit_count;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            OVERFLOW <= 1'b0;
        end else if (ovf_set) begin
            OVERFLOW <= 1'b1;
        end else if (OVF_CLEAR) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder: gesture-level model compared every cycle,
// plus literal expectations for each test-plan scenario.
module tb_click_decoder;

    localparam int W    = 20;
    localparam int MAXC = 3;

    logic       CLK;
    logic       RESETN;
    logic       EDGE_IN;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [1:0] OUT_COUNT;
    logic       OVERFLOW;
    logic       OVF_CLEAR;

    int errors = 0;
    int checks = 0;

    int ev_t[$];
    int ev_c[$];

    click_decoder #(
        .CLOCKS_PER_USEC  (100),
        .CLICK_WINDOW_MSEC(300),
        .MAX_CLICKS       (MAXC),
        .SIM_WINDOW_CYCLES(W)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .EDGE_IN  (EDGE_IN),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_COUNT(OUT_COUNT),
        .OVERFLOW (OVERFLOW),
        .OVF_CLEAR(OVF_CLEAR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Gesture model: absolute cycle numbers, a gesture closes W cycles after
    // its last click or immediately on reaching MAXC clicks.
    int   cyc, m_last, m_cnt, m_count;
    logic m_valid, m_ovf;
    int   nx_last, nx_cnt, nx_count, emit_n;
    logic nx_valid, nx_ovf, m_set;

    always_comb begin
        nx_cnt   = m_cnt;
        nx_last  = m_last;
        emit_n   = 0;
        nx_valid = m_valid;
        nx_count = m_count;
        nx_ovf   = m_ovf;
        m_set    = 1'b0;
        if (EDGE_IN) begin
            nx_cnt  = m_cnt + 1;
            nx_last = cyc + 1;
            if (nx_cnt == MAXC) begin
                emit_n = nx_cnt;
                nx_cnt = 0;
            end
        end else if (m_cnt > 0 && (cyc + 1) - m_last == W) begin
            emit_n = m_cnt;
            nx_cnt = 0;
        end
        if (emit_n != 0) begin
            if (!m_valid || OUT_READY) begin
                nx_valid = 1'b1;
                nx_count = emit_n;
            end else begin
                m_set = 1'b1;
            end
        end else if (m_valid && OUT_READY) begin
            nx_valid = 1'b0;
        end
        if (m_set) nx_ovf = 1'b1;
        else if (OVF_CLEAR) nx_ovf = 1'b0;
    end

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cyc     <= 0;
            m_last  <= 0;
            m_cnt   <= 0;
            m_count <= 0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            m_last  <= nx_last;
            m_cnt   <= nx_cnt;
            m_count <= nx_count;
            m_valid <= nx_valid;
            m_ovf   <= nx_ovf;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("model_valid", int'(OUT_VALID), int'(m_valid));
        chk("model_count", int'(OUT_COUNT), m_count);
        chk("model_ovf", int'(OVERFLOW), int'(m_ovf));
    end

    // Drives EDGE_IN on the listed relative cycles (-1 = unused) and records
    // every cycle OUT_VALID is seen high as (edge index, count).
    task automatic run_gesture(input int p0, input int p1, input int p2, input int p3,
                               input int clr_at, input int len);
        ev_t.delete();
        ev_c.delete();
        for (int i = 0; i <= len; i++) begin
            @(negedge CLK);
            if (i > 0 && OUT_VALID) begin
                ev_t.push_back(i - 1);
                ev_c.push_back(int'(OUT_COUNT));
            end
            if (i < len) begin
                EDGE_IN   = (i == p0) || (i == p1) || (i == p2) || (i == p3);
                OVF_CLEAR = (i == clr_at);
            end else begin
                EDGE_IN   = 1'b0;
                OVF_CLEAR = 1'b0;
            end
        end
    endtask

    function automatic int ev_at(input int idx, input bit want_count);
        if (idx >= ev_t.size()) return -1;
        return want_count ? ev_c[idx] : ev_t[idx];
    endfunction

    initial begin
        RESETN    = 1'b0;
        EDGE_IN   = 1'b0;
        OUT_READY = 1'b1;
        OVF_CLEAR = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_valid", int'(OUT_VALID), 0);
        chk("rst_count", int'(OUT_COUNT), 0);
        chk("rst_ovf", int'(OVERFLOW), 0);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);

        run_gesture(0, -1, -1, -1, -1, 45);
        chk("single_n", ev_t.size(), 1);
        chk("single_t", ev_at(0, 0), 20);
        chk("single_c", ev_at(0, 1), 1);

        run_gesture(0, 15, -1, -1, -1, 45);
        chk("double_n", ev_t.size(), 1);
        chk("double_t", ev_at(0, 0), 35);
        chk("double_c", ev_at(0, 1), 2);

        run_gesture(0, 21, -1, -1, -1, 50);
        chk("gap21_n", ev_t.size(), 2);
        chk("gap21_t0", ev_at(0, 0), 20);
        chk("gap21_c0", ev_at(0, 1), 1);
        chk("gap21_t1", ev_at(1, 0), 41);
        chk("gap21_c1", ev_at(1, 1), 1);

        run_gesture(0, 5, 10, 11, -1, 40);
        chk("max_n", ev_t.size(), 2);
        chk("max_t0", ev_at(0, 0), 10);
        chk("max_c0", ev_at(0, 1), 3);
        chk("max_t1", ev_at(1, 0), 31);
        chk("max_c1", ev_at(1, 1), 1);

        run_gesture(0, 20, -1, -1, -1, 45);
        chk("expiry_n", ev_t.size(), 1);
        chk("expiry_t", ev_at(0, 0), 40);
        chk("expiry_c", ev_at(0, 1), 2);

        // Second result dropped on the same cycle OVF_CLEAR is asserted: set wins.
        OUT_READY = 1'b0;
        run_gesture(0, 30, 35, -1, 55, 60);
        chk("bp_first_t", ev_at(0, 0), 20);
        chk("bp_held_c", int'(OUT_COUNT), 1);
        chk("bp_held_v", int'(OUT_VALID), 1);
        chk("bp_ovf", int'(OVERFLOW), 1);
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("bp_drain_v", int'(OUT_VALID), 0);
        chk("bp_drain_c", int'(OUT_COUNT), 1);
        chk("bp_ovf_kept", int'(OVERFLOW), 1);
        OVF_CLEAR = 1'b1;
        @(negedge CLK);
        OVF_CLEAR = 1'b0;
        chk("bp_ovf_clr", int'(OVERFLOW), 0);

        run_gesture(0, 5, -1, -1, -1, 10);
        #2 RESETN = 1'b0;
        @(negedge CLK);
        chk("mid_rst_valid", int'(OUT_VALID), 0);
        chk("mid_rst_count", int'(OUT_COUNT), 0);
        chk("mid_rst_ovf", int'(OVERFLOW), 0);
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        run_gesture(-1, -1, -1, -1, -1, 40);
        chk("mid_rst_none", ev_t.size(), 0);
        run_gesture(0, -1, -1, -1, -1, 25);
        chk("post_rst_n", ev_t.size(), 1);
        chk("post_rst_t", ev_at(0, 0), 20);
        chk("post_rst_c", ev_at(0, 1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
